// File: rtl/mulu_pkg.sv
// Shared definitions for the mulu arbiter: FSM state encoding, requester id type
// and the default operand width.
package mulu_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int ID_W          = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [ID_W-1:0] id_t;

endpackage : mulu_pkg

// File: rtl/mulu.sv
// Combinational unsigned multiplier; the product is full width, never truncated.
module mulu #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] p_o
);

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;

    assign a_ext = {{WIDTH{1'b0}}, a_i};
    assign b_ext = {{WIDTH{1'b0}}, b_i};
    assign p_o   = a_ext * b_ext;

endmodule : mulu

// File: rtl/mulu_arbiter.sv
// Round-robin arbiter and sequencer sharing one mulu between two requesters:
// IDLE grants and latches operands, MUL registers the product, DONE reports it.
module mulu_arbiter
    import mulu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    output logic               ack0,
    output logic               ack1,
    output logic               done0,
    output logic               done1,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    state_e             state_q, state_d;
    id_t                id_q;
    id_t                last_q;
    id_t                gnt_id;
    logic               grant;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [2*WIDTH-1:0] result_q;
    logic [2*WIDTH-1:0] prod;

    mulu #(.WIDTH(WIDTH)) u_mulu (
        .a_i (opa_q),
        .b_i (opb_q),
        .p_o (prod)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        gnt_id  = '0;

        // On a tie the requester not served last wins.
        if (req0 && req1) begin
            gnt_id = ~last_q;
        end else if (req1) begin
            gnt_id = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant   = 1'b1;
                    state_d = MUL;
                end
            end
            MUL:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            id_q     <= '0;
            last_q   <= 1'b1;
            // NOTE: operand and result registers are reset explicitly so the
            // multiplier input and the visible result never carry stale data.
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                id_q   <= gnt_id;
                last_q <= gnt_id;
                opa_q  <= (gnt_id == 1'b1) ? a1 : a0;
                opb_q  <= (gnt_id == 1'b1) ? b1 : b0;
            end
            if (state_q == MUL) begin
                result_q <= prod;
            end
        end
    end

    assign ack0   = (state_q == MUL)  && (id_q == 1'b0);
    assign ack1   = (state_q == MUL)  && (id_q == 1'b1);
    assign done0  = (state_q == DONE) && (id_q == 1'b0);
    assign done1  = (state_q == DONE) && (id_q == 1'b1);
    assign busy   = (state_q != IDLE);
    assign result = result_q;

endmodule : mulu_arbiter

// File: tb/tb_mulu_arbiter.sv
// Scoreboard bench for mulu_arbiter: a transaction-level model predicts grants,
// acks, completions and products; a negedge monitor compares every cycle.
module tb_mulu_arbiter;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               req0, req1;
    logic [WIDTH-1:0]   a0, b0, a1, b1;
    logic               ack0, ack1, done0, done1, busy;
    logic [2*WIDTH-1:0] result;

    mulu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .a0     (a0),
        .b0     (b0),
        .req1   (req1),
        .a1     (a1),
        .b1     (b1),
        .ack0   (ack0),
        .ack1   (ack1),
        .done0  (done0),
        .done1  (done1),
        .result (result),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic id;
        int   prod;
        int   cyc;
    } exp_t;

    exp_t ack_q[$];
    exp_t done_q[$];

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   busy_last = -1;
    int   last_rst_cyc = -10;
    logic last_id = 1'b1;
    bit   started = 1'b0;
    int   exp_result = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: an operation granted at edge g acks in the cycle after g,
    // completes one cycle later, and the unit can grant again at edge g+3.
    always @(posedge clk) begin
        logic w;
        int   p;
        cyc++;
        if (rst) begin
            started      = 1'b1;
            ack_q.delete();
            done_q.delete();
            busy_last    = -1;
            last_id      = 1'b1;
            last_rst_cyc = cyc;
        end else if (started && cyc >= busy_last + 2 && (req0 || req1)) begin
            w = (req0 && req1) ? ~last_id : req1;
            p = w ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
            last_id = w;
            ack_q.push_back('{id: w, prod: p, cyc: cyc});
            done_q.push_back('{id: w, prod: p, cyc: cyc + 1});
            busy_last = cyc + 1;
        end
    end

    // Monitor: compares the DUT outputs against the scoreboard every cycle.
    always @(negedge clk) begin
        int exp_ack;
        int exp_done;
        if (started) begin
            if (last_rst_cyc == cyc) exp_result = 0;

            exp_ack = 0;
            if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
                exp_ack = ack_q[0].id ? 2 : 1;
                ack_q.delete(0);
            end
            check("ack", int'({ack1, ack0}), exp_ack);

            exp_done = 0;
            if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
                exp_done   = done_q[0].id ? 2 : 1;
                exp_result = done_q[0].prod;
                done_q.delete(0);
            end
            check("done", int'({done1, done0}), exp_done);
            check("result", int'(result), exp_result);
            check("busy", int'(busy), int'(cyc <= busy_last));
        end
    end

    task automatic drive(input logic r, input logic r0, input logic [WIDTH-1:0] x0,
                         input logic [WIDTH-1:0] y0, input logic r1,
                         input logic [WIDTH-1:0] x1, input logic [WIDTH-1:0] y1);
        rst  = r;
        req0 = r0; a0 = x0; b0 = y0;
        req1 = r1; a1 = x1; b1 = y1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Single request from requester 0: 12*13.
        drive(0, 1, 8'd12, 8'd13, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0);

        // Requester 1 with maximum operands, then idle to see result held.
        drive(0, 0, 0, 0, 1, 8'hFF, 8'hFF);
        repeat (6) drive(0, 0, 0, 0, 0, 0, 0);

        // Both requesting continuously from reset: alternation 12, 30, 12, ...
        drive(1, 1, 8'd3, 8'd4, 1, 8'd5, 8'd6);
        repeat (14) drive(0, 1, 8'd3, 8'd4, 1, 8'd5, 8'd6);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0);

        // Zero operand; multiplicand changes while the operation is in flight.
        drive(0, 1, 8'hA5, 8'h00, 0, 0, 0);
        drive(0, 0, 8'h01, 8'h00, 0, 0, 0);
        repeat (3) drive(0, 0, 8'h01, 8'h00, 0, 0, 0);

        // Reset during MUL of 7*9, then a fresh tie that requester 0 must win.
        drive(0, 1, 8'd7, 8'd9, 0, 0, 0);
        drive(1, 0, 8'd7, 8'd9, 0, 0, 0);
        drive(0, 1, 8'd7, 8'd9, 1, 8'd2, 8'd11);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0);

        // Requester 0 streaming alone, then requester 1 joins mid-stream.
        repeat (7) drive(0, 1, 8'd10, 8'd20, 0, 0, 0);
        repeat (8) drive(0, 1, 8'd10, 8'd20, 1, 8'd40, 8'd50);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 2) != 0), rnd_op(), rnd_op(),
                  ($urandom_range(0, 2) != 0), rnd_op(), rnd_op());
        end

        repeat (6) drive(0, 0, 0, 0, 0, 0, 0);
        check("drain_ack", ack_q.size(), 0);
        check("drain_done", done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mulu_arbiter
